// File: rtl/zmem_pkg.sv
// Shared types and helpers for the Z memory access controller.
package zmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef enum logic {
        REQ_WRITE = 1'b0,
        REQ_SWEEP = 1'b1
    } req_e;

    // Two rows are read per cycle; an odd row count leaves a half-used final pair.
    function automatic int unsigned pairs_per_col(input int unsigned n);
        return (n + 1) / 2;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zmem_rd_tag_pipe.sv
// Delays the read tag so it lines up with data returning from the memory.
module zmem_rd_tag_pipe #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_tag,
    output logic [WIDTH-1:0] o_tag
);

    logic [WIDTH-1:0] r_pipe [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tag = r_pipe[LATENCY-1];

endmodule

// File: rtl/zmem_access_ctrl.sv
// Owns the Z memory: arbitrates loader writes against full-matrix sweeps
// and streams tagged row pairs back to the update engine.
module zmem_access_ctrl
    import zmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned M          = 1024,
    parameter int unsigned N          = 7,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [$clog2(N)-1:0]  i_wr_row,
    input  logic [$clog2(M)-1:0]  i_wr_col,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_err,
    input  logic                  i_sweep_start,
    output logic                  o_sweep_busy,
    output logic                  o_sweep_done,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data0,
    output logic [DATA_WIDTH-1:0] o_rd_data1,
    output logic [1:0]            o_rd_mask,
    output logic [$clog2(M)-1:0]  o_rd_col,
    output logic                  o_rd_last,
    output logic                  o_mem_read_en,
    output logic                  o_mem_write_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr1,
    output logic [ADDR_WIDTH-1:0] o_mem_addr2,
    output logic [DATA_WIDTH-1:0] o_mem_din1,
    input  logic [DATA_WIDTH-1:0] i_mem_dout1,
    input  logic [DATA_WIDTH-1:0] i_mem_dout2,
    input  logic                  i_mem_dout_valid
);

    localparam int unsigned CW    = $clog2(M);
    localparam int unsigned P     = pairs_per_col(N);
    localparam int unsigned PW    = idx_width(P);
    localparam bit          ODD_N = (N % 2) == 1;

    typedef struct packed {
        logic          valid;
        logic [1:0]    mask;
        logic [CW-1:0] col;
        logic          last;
        logic          fin;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

    state_e        r_state;
    req_e          r_rr_last;
    logic [CW-1:0] r_col;
    logic [PW-1:0] r_pair;
    logic          r_wr_err;

    logic                  w_wr_oob;
    logic                  w_wr_grant;
    logic                  w_sw_grant;
    logic                  w_in_sweep;
    logic                  w_last_pair;
    logic                  w_last_col;
    logic                  w_odd_tail;
    logic                  w_rd_fire;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_base;
    logic [ADDR_WIDTH-1:0] w_rd_addr1;
    logic [ADDR_WIDTH-1:0] w_rd_addr2;
    tag_t                  w_tag_in;
    tag_t                  w_tag_out;

    // Arbitration: on a tie, the requester that did not win last time goes.
    assign w_wr_grant = !rst && (r_state == IDLE) && i_wr_valid &&
                        (!i_sweep_start || (r_rr_last == REQ_SWEEP));
    assign w_sw_grant = (r_state == IDLE) && i_sweep_start &&
                        (!i_wr_valid || (r_rr_last == REQ_WRITE));
    assign w_wr_oob   = (32'(i_wr_row) >= N) || (32'(i_wr_col) >= M);
    assign w_wr_addr  = ADDR_WIDTH'(i_wr_col) * ADDR_WIDTH'(N) + ADDR_WIDTH'(i_wr_row);

    assign w_in_sweep  = (r_state == SWEEP);
    assign w_last_pair = (32'(r_pair) == P - 1);
    assign w_last_col  = (32'(r_col) == M - 1);
    assign w_odd_tail  = ODD_N && w_last_pair;
    assign w_rd_base   = ADDR_WIDTH'(r_col) * ADDR_WIDTH'(N);
    assign w_rd_addr1  = w_rd_base + ADDR_WIDTH'({r_pair, 1'b0});
    assign w_rd_addr2  = w_odd_tail ? w_rd_addr1 : w_rd_addr1 + ADDR_WIDTH'(1);

    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = w_in_sweep;
        w_tag_in.mask  = w_odd_tail ? 2'b01 : 2'b11;
        w_tag_in.col   = r_col;
        w_tag_in.last  = w_last_pair;
        w_tag_in.fin   = w_last_pair && w_last_col;
    end

    zmem_rd_tag_pipe #(
        .WIDTH   (TAG_W),
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rr_last <= REQ_WRITE;
            r_col     <= '0;
            r_pair    <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            r_wr_err <= w_wr_grant && w_wr_oob;
            case (r_state)
                IDLE: begin
                    if (w_sw_grant) begin
                        r_state   <= SWEEP;
                        r_rr_last <= REQ_SWEEP;
                        r_col     <= '0;
                        r_pair    <= '0;
                    end else if (w_wr_grant) begin
                        r_rr_last <= REQ_WRITE;
                    end
                end
                SWEEP: begin
                    if (w_last_pair) begin
                        r_pair <= '0;
                        if (w_last_col) begin
                            r_state <= DRAIN;
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end else begin
                        r_pair <= r_pair + PW'(1);
                    end
                end
                DRAIN: begin
                    // Leave once the final pair's tag has come out of the pipe.
                    if (w_tag_out.valid && w_tag_out.fin) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_wr_ready     = w_wr_grant;
    assign o_wr_err       = r_wr_err;
    assign o_mem_write_en = w_wr_grant && !w_wr_oob;
    assign o_mem_read_en  = w_in_sweep;
    assign o_mem_addr1    = w_in_sweep ? w_rd_addr1 : (o_mem_write_en ? w_wr_addr : '0);
    assign o_mem_addr2    = w_in_sweep ? w_rd_addr2 : '0;
    assign o_mem_din1     = o_mem_write_en ? i_wr_data : '0;
    assign o_sweep_busy   = (r_state != IDLE);

    // Read side is unregistered: tag and memory data meet combinationally.
    assign w_rd_fire    = i_mem_dout_valid && w_tag_out.valid;
    assign o_rd_valid   = w_rd_fire;
    assign o_rd_data0   = w_rd_fire ? i_mem_dout1 : '0;
    assign o_rd_data1   = w_rd_fire ? i_mem_dout2 : '0;
    assign o_rd_mask    = w_rd_fire ? w_tag_out.mask : 2'b00;
    assign o_rd_col     = w_rd_fire ? w_tag_out.col : '0;
    assign o_rd_last    = w_rd_fire && w_tag_out.last;
    assign o_sweep_done = w_tag_out.valid && w_tag_out.fin;

endmodule
